array_serializer: RTL

ARRAY_SERIALIZER -- requirements
Module: array_serializer

---
 rtl/array_serializer.sv | 68 ++++++
 1 files changed

// File: rtl/array_serializer.sv
// rtl/array_serializer.sv - serializes a packed N x W array into W-bit beats, MSB element first.
// Optional macro ARRAY_SERIALIZER_PARITY_EN adds o_parity (XOR of o_data bits).
module array_serializer #(
  parameter int N = 3,
  parameter int W = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [N-1:0][W-1:0]   i_data,
  output logic                  i_ready,
  output logic                  o_valid,
  output logic [W-1:0]          o_data,
  output logic [IW-1:0]         o_index,
  output logic                  o_last,
`ifdef ARRAY_SERIALIZER_PARITY_EN
  output logic                  o_parity,
`endif
  input  logic                  o_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q;
  logic [N-1:0][W-1:0] buf_q;
  logic [IW-1:0]       idx_q;

  logic send;
  logic last_idx;
  logic xfer;
  logic capture;

  assign send     = (state_q == SEND);
  assign last_idx = (idx_q == '0);
  assign xfer     = send && o_ready;
  // A new array may land on the final-beat transfer so back-to-back arrays have no bubble.
  assign i_ready  = !send || (last_idx && o_ready);
  assign capture  = i_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else if (capture) begin
      state_q <= SEND;
      buf_q   <= i_data;
      idx_q   <= IW'(N - 1);
    end else if (xfer) begin
      if (last_idx) begin
        state_q <= IDLE;
      end else begin
        idx_q <= idx_q - IW'(1);
      end
    end
  end

  assign o_valid = send;
  assign o_data  = send ? buf_q[idx_q] : '0;
  assign o_index = send ? idx_q : '0;
  assign o_last  = send && last_idx;

`ifdef ARRAY_SERIALIZER_PARITY_EN
  assign o_parity = ^o_data;
`endif

endmodule
